// File: rtl/stream_demux_pkg.sv
// ----------------------------------------------------------------------------
// stream_demux_pkg
//   Shared helpers for the stream_demux block.
//   Contents:
//     sd_sel_nbits(n) - width of a select field able to index n outputs
//                       (never narrower than one bit).
// ----------------------------------------------------------------------------
package stream_demux_pkg;

    function automatic int sd_sel_nbits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stream_demux_entry.sv
// ----------------------------------------------------------------------------
// stream_demux_entry
//   One-entry pipeline register for a single demux output.
//   Ports:
//     clk        - clock, rising edge
//     reset_n    - asynchronous active-low reset (empties entry, clears data)
//     i_enq_en   - write i_enq_msg into the entry this edge
//     i_enq_msg  - payload to store
//     i_deq_en   - consumer takes the stored payload this edge
//     o_full     - entry holds a valid payload (drives out_val)
//     o_data     - stored payload; holds its last value when empty
// ----------------------------------------------------------------------------
module stream_demux_entry #(
    parameter int p_nbits = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i_enq_en,
    input  logic [p_nbits-1:0] i_enq_msg,
    input  logic               i_deq_en,
    output logic               o_full,
    output logic [p_nbits-1:0] o_data
);

    logic               r_full;
    logic [p_nbits-1:0] r_data;

    // Enqueue wins over dequeue: a same-cycle drain and refill keeps the
    // entry full with the new payload, so there is no bubble.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (i_enq_en) begin
            r_full <= 1'b1;
            r_data <= i_enq_msg;
        end else if (i_deq_en) begin
            r_full <= 1'b0;
        end
    end

    assign o_full = r_full;
    assign o_data = r_data;

endmodule

// File: rtl/stream_demux.sv
// ----------------------------------------------------------------------------
// stream_demux
//   Registered one-to-N stream demultiplexer. One input stream is steered to
//   output in_sel; each output has its own one-entry register so a stall on
//   one output never blocks traffic to the others.
//
//   Handshake: a transfer happens on a rising edge where val && rdy are both
//   high; val must not depend on rdy, while in_rdy here depends
//   combinationally on out_rdy[in_sel] so a full entry can drain and refill
//   in the same cycle.
//
//   Ports:
//     clk, reset_n  - clock; asynchronous active-low reset
//     in_val/in_rdy - input handshake; in_rdy is 0 while in reset
//     in_msg        - input payload
//     in_sel        - destination index; values >= p_nout are dropped
//     out_val       - per-output valid (bit i = output i)
//     out_rdy       - per-output ready (bit i = output i)
//     out_msg       - flattened payloads, output i at [i*p_nbits +: p_nbits]
//     err           - sticky: an illegal in_sel was accepted since reset
// ----------------------------------------------------------------------------
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int p_nbits     = 8,
    parameter int p_nout      = 2,
    parameter int p_sel_nbits = sd_sel_nbits(p_nout)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       in_val,
    output logic                       in_rdy,
    input  logic [p_nbits-1:0]         in_msg,
    input  logic [p_sel_nbits-1:0]     in_sel,
    output logic [p_nout-1:0]          out_val,
    input  logic [p_nout-1:0]          out_rdy,
    output logic [p_nout*p_nbits-1:0]  out_msg,
    output logic                       err
);

    logic [p_nout-1:0] w_full;
    logic [p_nout-1:0] w_dest;
    logic [p_nout-1:0] w_enq;
    logic [p_nout-1:0] w_deq;
    logic              w_sel_legal;
    logic              w_sel_full;
    logic              w_sel_rdy;
    logic              w_in_fire;
    logic              r_err;

    // Select decode by explicit match so an out-of-range in_sel simply
    // matches nothing instead of indexing past the vectors.
    always_comb begin
        w_dest      = '0;
        w_sel_legal = 1'b0;
        w_sel_full  = 1'b0;
        w_sel_rdy   = 1'b0;
        for (int i = 0; i < p_nout; i++) begin
            if (in_sel == p_sel_nbits'(i)) begin
                w_dest[i]   = 1'b1;
                w_sel_legal = 1'b1;
                w_sel_full  = w_full[i];
                w_sel_rdy   = out_rdy[i];
            end
        end
    end

    // Illegal selects are always accepted (and dropped) so the producer
    // cannot deadlock on a bad index.
    assign in_rdy    = reset_n && (!w_sel_legal || !w_sel_full || w_sel_rdy);
    assign w_in_fire = in_val && in_rdy;
    assign w_enq     = w_dest & {p_nout{w_in_fire}};
    assign w_deq     = w_full & out_rdy;

    for (genvar g = 0; g < p_nout; g++) begin : g_entry
        stream_demux_entry #(
            .p_nbits (p_nbits)
        ) u_entry (
            .clk       (clk),
            .reset_n   (reset_n),
            .i_enq_en  (w_enq[g]),
            .i_enq_msg (in_msg),
            .i_deq_en  (w_deq[g]),
            .o_full    (w_full[g]),
            .o_data    (out_msg[g*p_nbits +: p_nbits])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else if (w_in_fire && !w_sel_legal) begin
            r_err <= 1'b1;
        end
    end

    assign out_val = w_full;
    assign err     = r_err;

endmodule
